demux1_4_stream: RTL and testbench

DEMUX1_4_STREAM -- requirements
Module: demux1_4_stream

---
 rtl/demux1_4_stream.sv | 84 ++++++++
 tb/tb_demux1_4_stream.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/demux1_4_stream.sv
// 1-to-4 stream demultiplexer with one holding slot per output channel.
// The selected slot loads on an input transfer and drains through its own valid/ready handshake.
module demux1_4_stream #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   in_data,
    input  logic               in_valid,
    input  logic [1:0]         select,
    output logic               in_ready,
    output logic [4*WIDTH-1:0] out_data,
    output logic [3:0]         out_valid,
    input  logic [3:0]         out_ready,
    output logic [2:0]         occupancy
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_t;

    slot_state_t      state     [4];
    logic [WIDTH-1:0] slot_data [4];

    logic       in_xfer;
    logic [3:0] load;
    logic [3:0] take;
    logic [3:0] full_next;
    logic [2:0] occ_next;

    // A full slot can still accept if its sink drains it on the same edge.
    always_comb begin
        in_ready = (state[select] == EMPTY) || out_ready[select];
    end

    assign in_xfer = in_valid && in_ready;

    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        load      = '0;
        take      = '0;
        full_next = '0;
        occ_next  = '0;
        for (int i = 0; i < 4; i++) begin
            load[i]      = in_xfer && (select == 2'(i));
            take[i]      = (state[i] == FULL) && out_ready[i];
            full_next[i] = load[i] || ((state[i] == FULL) && !take[i]);
            occ_next     = occ_next + 3'(full_next[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the data slots are reset as well, since out_data must read zero during reset.
            for (int i = 0; i < 4; i++) begin
                state[i]     <= EMPTY;
                slot_data[i] <= '0;
            end
            occupancy <= '0;
        end else begin
            // NOTE: non-blocking assignments so every slot updates from the same pre-edge state.
            for (int i = 0; i < 4; i++) begin
                if (load[i]) begin
                    state[i]     <= FULL;
                    slot_data[i] <= in_data;
                end else if (take[i]) begin
                    state[i]     <= EMPTY;
                end
            end
            occupancy <= occ_next;
        end
    end

    always_comb begin
        out_valid = '0;
        out_data  = '0;
        for (int i = 0; i < 4; i++) begin
            out_valid[i]                = (state[i] == FULL);
            out_data[i*WIDTH +: WIDTH]  = slot_data[i];
        end
    end

endmodule

// File: tb/tb_demux1_4_stream.sv
// Self-checking bench for demux1_4_stream: directed scenarios then randomized traffic
// compared against a per-channel "holds a word" reference model.
module tb_demux1_4_stream;

    localparam int WIDTH = 8;

    logic               clk = 1'b0;
    logic               rst;
    logic [WIDTH-1:0]   in_data;
    logic               in_valid;
    logic [1:0]         select;
    logic               in_ready;
    logic [4*WIDTH-1:0] out_data;
    logic [3:0]         out_valid;
    logic [3:0]         out_ready;
    logic [2:0]         occupancy;

    demux1_4_stream #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .select    (select),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: each channel either holds a word or not.
    logic [WIDTH-1:0] m_data [4];
    logic [3:0]       m_valid;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_out_data();
        return {m_data[3], m_data[2], m_data[1], m_data[0]};
    endfunction

    function automatic logic m_ready();
        return !m_valid[select] || out_ready[select];
    endfunction

    task automatic m_clear();
        m_valid = '0;
        for (int i = 0; i < 4; i++) m_data[i] = '0;
    endtask

    task automatic check_model(input string tag);
        chk({tag, " out_valid"}, 32'(out_valid), 32'(m_valid));
        chk({tag, " out_data"},  32'(out_data),  m_out_data());
        chk({tag, " occupancy"}, 32'(occupancy), 32'($countones(m_valid)));
    endtask

    task automatic check_ready(input string tag);
        #1;
        chk({tag, " in_ready"}, 32'(in_ready), 32'(m_ready()));
    endtask

    // One clock edge: the model applies the transfer rules to the inputs held across the edge.
    task automatic cycle();
        logic             acc;
        logic [3:0]       nv;
        logic [WIDTH-1:0] nd [4];
        acc = in_valid && m_ready();
        nv  = m_valid;
        for (int n = 0; n < 4; n++) begin
            nd[n] = m_data[n];
            if (acc && select == 2'(n)) begin
                nd[n] = in_data;
                nv[n] = 1'b1;
            end else if (m_valid[n] && out_ready[n]) begin
                nv[n] = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        m_valid = nv;
        for (int n = 0; n < 4; n++) m_data[n] = nd[n];
    endtask

    task automatic send(input logic [1:0] sel, input logic [WIDTH-1:0] d);
        in_valid = 1'b1;
        select   = sel;
        in_data  = d;
        cycle();
        in_valid = 1'b0;
    endtask

    logic hold;

    initial begin
        rst       = 1'b1;
        in_data   = '0;
        in_valid  = 1'b0;
        select    = '0;
        out_ready = '0;
        m_clear();

        // Reset state, before and after a clock edge.
        #1;
        chk("rst out_valid", 32'(out_valid), 32'h0);
        chk("rst out_data", 32'(out_data), 32'h0);
        chk("rst occupancy", 32'(occupancy), 32'h0);
        @(posedge clk);
        #1;
        check_model("rst after edge");
        rst = 1'b0;
        for (int s = 0; s < 4; s++) begin
            select = 2'(s);
            #1;
            chk("post-reset in_ready", 32'(in_ready), 32'h1);
        end

        // Basic routing.
        send(2'b10, 8'hA5);
        chk("route out_valid", 32'(out_valid), 32'h4);
        chk("route ch2", 32'(out_data[2*WIDTH +: WIDTH]), 32'hA5);
        chk("route occupancy", 32'(occupancy), 32'h1);
        select = 2'b10;
        #1;
        chk("route in_ready sel2", 32'(in_ready), 32'h0);
        select = 2'b00;
        #1;
        chk("route in_ready sel0", 32'(in_ready), 32'h1);

        // Backpressure, then simultaneous drain and load on ch2.
        in_valid = 1'b1;
        select   = 2'b10;
        in_data  = 8'h3C;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp in_ready", 32'(in_ready), 32'h0);
            cycle();
            chk("bp ch2 stable", 32'(out_data[2*WIDTH +: WIDTH]), 32'hA5);
        end
        out_ready = 4'b0100;
        #1;
        chk("bp release in_ready", 32'(in_ready), 32'h1);
        cycle();
        in_valid  = 1'b0;
        out_ready = 4'b0000;
        chk("bp swap valid", 32'(out_valid[2]), 32'h1);
        chk("bp swap ch2", 32'(out_data[2*WIDTH +: WIDTH]), 32'h3C);
        check_model("bp swap");
        out_ready = 4'b0100;
        cycle();
        out_ready = 4'b0000;
        chk("bp drained", 32'(out_valid), 32'h0);

        // Full fan-out.
        send(2'b00, 8'h11);
        send(2'b01, 8'h22);
        send(2'b10, 8'h33);
        send(2'b11, 8'h44);
        chk("fan out_valid", 32'(out_valid), 32'hF);
        chk("fan occupancy", 32'(occupancy), 32'h4);
        chk("fan out_data", 32'(out_data), 32'h44332211);
        out_ready = 4'b1111;
        cycle();
        out_ready = 4'b0000;
        chk("fan drain valid", 32'(out_valid), 32'h0);
        chk("fan drain occupancy", 32'(occupancy), 32'h0);

        // Streaming on ch1.
        out_ready = 4'b0010;
        in_valid  = 1'b1;
        select    = 2'b01;
        for (int k = 0; k < 8; k++) begin
            in_data = 8'h50 + 8'(k);
            #1;
            chk("stream in_ready", 32'(in_ready), 32'h1);
            cycle();
            chk("stream ch1", 32'(out_data[WIDTH +: WIDTH]), 32'h50 + 32'(k));
            chk("stream valid", 32'(out_valid[1]), 32'h1);
        end
        in_valid = 1'b0;
        cycle();
        out_ready = 4'b0000;
        check_model("stream end");

        // Reset between clock edges with ch0 and ch3 full.
        send(2'b00, 8'h77);
        send(2'b11, 8'h88);
        chk("pre-rst out_valid", 32'(out_valid), 32'h9);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst out_valid", 32'(out_valid), 32'h0);
        chk("midrst out_data", 32'(out_data), 32'h0);
        chk("midrst occupancy", 32'(occupancy), 32'h0);
        m_clear();
        @(negedge clk);
        rst       = 1'b0;
        out_ready = 4'b1111;
        for (int k = 0; k < 3; k++) begin
            cycle();
            check_model("post-rst");
        end
        out_ready = 4'b0000;

        // Idle input with toggling select and data.
        send(2'b01, 8'hC1);
        send(2'b10, 8'hC2);
        for (int k = 0; k < 10; k++) begin
            select  = 2'($urandom_range(0, 3));
            in_data = 8'($urandom);
            cycle();
            chk("idle out_valid", 32'(out_valid), 32'h6);
            chk("idle occupancy", 32'(occupancy), 32'h2);
        end
        check_model("idle");

        // Randomized traffic against the model; source holds its offer until accepted.
        hold = 1'b0;
        for (int k = 0; k < 400; k++) begin
            out_ready = 4'($urandom);
            if (!hold) begin
                in_valid = ($urandom_range(0, 3) != 0);
                select   = 2'($urandom_range(0, 3));
                in_data  = 8'($urandom);
            end
            check_ready("rand");
            hold = in_valid && !m_ready();
            cycle();
            check_model("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
